// File: rtl/pair_average_stream.sv
// ---------------------------------------------------------------------------
// pair_average_stream
//
// Captures a frame of DEPTH samples, then streams DEPTH-STRIDE averages
// avg(s[j], s[j+STRIDE]) for j = 0 .. DEPTH-STRIDE-1 through a valid/ready
// output with backpressure. The final average carries 'last'. The block then
// parks in DONE until 'restart' starts the next frame.
//
// Sequence: CAPTURE -> EMIT -> DONE -> CAPTURE
//
// Parameters
//   DATA_W  sample / result width
//   DEPTH   samples per frame (>= 2)
//   STRIDE  index distance of the averaged pair (1 <= STRIDE < DEPTH)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   input sample valid
//   data       input sample
//   in_ready   sample accepted this cycle (CAPTURE only)
//   out_ready  consumer accepts 'out' this cycle
//   valid      'out' holds an average
//   out        registered average
//   last       final average of the frame (qualified by valid)
//   done       block is in DONE
//   restart    one-cycle pulse, honoured only in DONE
//
// Build option
//   PAIR_AVG_TRUNC_EN  defined: out = sum >> 1 (truncate)
//                      default: out = (sum + 1) >> 1 (round half up)
// ---------------------------------------------------------------------------
module pair_average_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int STRIDE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              valid,
    output logic [DATA_W-1:0] out,
    output logic              last,
    output logic              done,
    input  logic              restart
);

    // Counters are wide enough to hold DEPTH itself; memory index only
    // needs enough bits to address DEPTH entries.
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int NOUT = DEPTH - STRIDE;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] J_END    = CW'(NOUT);
    localparam logic [CW-1:0] J_LAST   = CW'(NOUT - 1);
    localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);

    localparam logic [1:0] CAPTURE = 2'd0;
    localparam logic [1:0] EMIT    = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;     // capture write index
    logic [CW-1:0]     j;       // emit index of the next average to load
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              load;
    logic              consume_last;
    logic [AW-1:0]     idx_a;
    logic [AW-1:0]     idx_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] avg;

    assign in_ready = (state == CAPTURE);
    assign done     = (state == DONE);
    assign accept   = in_ready && in_valid;

    // The output register refills whenever it is empty or being drained,
    // which gives one result per cycle under continuous out_ready.
    // Once the last average is loaded j == J_END, so load stays low
    // until the frame is closed.
    assign load         = (state == EMIT) && (!valid || out_ready) && (j < J_END);
    assign consume_last = valid && out_ready && last;

    // ------------------------------------------------------------------
    // Pair read and average
    // ------------------------------------------------------------------
    // j < DEPTH-STRIDE whenever load is high, so idx_b never wraps on a
    // cycle whose result is actually used.
    assign idx_a = j[AW-1:0];
    assign idx_b = idx_a + STRIDE_A;
    assign sum   = {1'b0, mem[idx_a]} + {1'b0, mem[idx_b]};

    // sum <= 2*(2^DATA_W - 1), so sum + 1 still fits in DATA_W+1 bits and
    // the halved result always fits in DATA_W bits.
`ifdef PAIR_AVG_TRUNC_EN
    assign avg = DATA_W'(sum >> 1);
`else
    assign avg = DATA_W'((sum + (DATA_W + 1)'(1)) >> 1);
`endif

    // ------------------------------------------------------------------
    // Sample memory: no reset, every frame rewrites all DEPTH entries
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[cnt[AW-1:0]] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Control and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CAPTURE;
            cnt   <= '0;
            j     <= '0;
            valid <= 1'b0;
            out   <= '0;
            last  <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= EMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (consume_last) begin
                        // Frame closed: drop the output and rewind j.
                        valid <= 1'b0;
                        last  <= 1'b0;
                        j     <= '0;
                        state <= DONE;
                    end else if (load) begin
                        out   <= avg;
                        valid <= 1'b1;
                        last  <= (j == J_LAST);
                        j     <= j + 1'b1;
                    end
                end

                DONE: begin
                    if (restart) begin
                        cnt   <= '0;
                        state <= CAPTURE;
                    end
                end

                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_average_stream.sv
// ---------------------------------------------------------------------------
// tb_pair_average_stream
//
// Randomised frames (ramp, reverse ramp, random, sparse pair, all-ones) are
// pushed through pair_average_stream with input gaps and output
// backpressure. Expected averages come from plain arithmetic over the frame
// array. Also covers restart in EMIT / DONE and async reset mid-EMIT and
// mid-CAPTURE. Inputs change on the falling edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pair_average_stream;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int STRIDE = 8;
    localparam int NOUT   = DEPTH - STRIDE;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] data      = '0;
    logic              out_ready = 1'b0;
    logic              restart   = 1'b0;
    logic              in_ready;
    logic              valid;
    logic [DATA_W-1:0] out;
    logic              last;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;
    int samp [DEPTH];
    int expq [NOUT];

    pair_average_stream #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .STRIDE (STRIDE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data      (data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .valid     (valid),
        .out       (out),
        .last      (last),
        .done      (done),
        .restart   (restart)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Frame contents and the averages the frame must produce.
    task automatic build(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            case (mode)
                0:       samp[i] = i;
                1:       samp[i] = 255 - i;
                2:       samp[i] = int'($urandom_range(0, 255));
                3:       samp[i] = (i == 0) ? 3 : ((i == STRIDE) ? 4 : 0);
                default: samp[i] = 255;
            endcase
        end
        for (int k = 0; k < NOUT; k++) begin
`ifdef PAIR_AVG_TRUNC_EN
            expq[k] = (samp[k] + samp[k + STRIDE]) / 2;
`else
            expq[k] = (samp[k] + samp[k + STRIDE] + 1) / 2;
`endif
        end
    endtask

    // Feed samples 0..stop_at-1. gap_mode: 0 none, 1 every other cycle,
    // 2 random gaps plus stray restart pulses that must be ignored.
    task automatic capture(input int gap_mode, input int stop_at);
        int   acc = 0;
        int   cyc = 0;
        logic go;
        while (acc < stop_at) begin
            if (cyc >= 8 * DEPTH) begin
                chk("cap_timeout", acc, stop_at);
                return;
            end
            chk("cap_in_ready", in_ready, 1);
            chk("cap_valid", valid, 0);
            chk("cap_done", done, 0);
            case (gap_mode)
                0:       go = 1'b1;
                1:       go = (cyc % 2 == 0);
                default: go = ($urandom_range(0, 2) != 0);
            endcase
            in_valid  = go;
            data      = go ? DATA_W'(samp[acc]) : DATA_W'($urandom);
            restart   = (gap_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (go) acc++;
            cyc++;
        end
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    // Drain the frame. bp_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // abort_at >= 0 returns early at that cycle (for the reset test).
    task automatic emit(input int bp_mode, input bit restart_pulse, input int abort_at);
        int   k   = 0;
        int   cyc = 0;
        logic rdy;
        chk("emit_entry_in_ready", in_ready, 0);
        chk("emit_entry_valid", valid, 0);
        while (k < NOUT) begin
            if (cyc >= 20 * NOUT) begin
                chk("emit_timeout", k, NOUT);
                return;
            end
            if (cyc == abort_at) return;
            if (cyc > 0) begin
                chk("emit_valid", valid, 1);
                chk("emit_out", out, expq[k]);
                chk("emit_last", last, (k == NOUT - 1));
                chk("emit_in_ready", in_ready, 0);
                chk("emit_done", done, 0);
            end
            case (bp_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            restart   = restart_pulse && (cyc == 5);
            in_valid  = 1'($urandom_range(0, 1));
            data      = DATA_W'($urandom);
            step();
            if (cyc > 0 && rdy) k++;
            cyc++;
        end
        restart  = 1'b0;
        in_valid = 1'b0;
        chk("post_valid", valid, 0);
        chk("post_last", last, 0);
        chk("post_done", done, 1);
        chk("post_in_ready", in_ready, 0);
    endtask

    task automatic finish_done();
        int n = int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            chk("done_hold", done, 1);
            chk("done_valid", valid, 0);
            chk("done_in_ready", in_ready, 0);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_in_ready", in_ready, 1);
        chk("restart_valid", valid, 0);
    endtask

    task automatic run_frame(input int mode, input int gap_mode, input int bp_mode, input bit rp);
        build(mode);
        capture(gap_mode, DEPTH);
        emit(bp_mode, rp, -1);
        finish_done();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_out"}, out, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 check_reset_state("rst0");
        step();
        step();
        reset = 1'b1;

        run_frame(0, 0, 0, 1'b0);   // ramp, full throughput
        run_frame(3, 0, 0, 1'b0);   // sparse pair: first out 4 (3 truncating)
        run_frame(4, 0, 0, 1'b0);   // all 255, no overflow
        run_frame(0, 0, 1, 1'b0);   // 1,0,0,1 backpressure
        run_frame(0, 1, 0, 1'b0);   // every-other-cycle input gaps
        run_frame(1, 0, 2, 1'b1);   // reverse ramp, restart pulsed in EMIT
        run_frame(2, 2, 2, 1'b0);   // random data, gaps, backpressure

        // Async reset mid-EMIT: outputs drop before the next edge.
        build(0);
        capture(0, DEPTH);
        emit(0, 1'b0, 30);
        reset = 1'b0;
        #1 check_reset_state("rst_emit");
        step();
        reset = 1'b1;
        run_frame(0, 0, 0, 1'b0);

        // Async reset mid-CAPTURE: next frame must start from index 0.
        build(2);
        capture(0, 50);
        reset = 1'b0;
        #1 check_reset_state("rst_cap");
        step();
        reset = 1'b1;
        run_frame(2, 0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pair_average_stream.md
Name: pair_average_stream

Overview:
- Parametrised successor to the capture-then-average block: buffers a frame of DEPTH samples, then streams DEPTH-STRIDE pairwise averages avg(s[j], s[j+STRIDE]) for j = 0..DEPTH-STRIDE-1.
- Adds the following over the previous generation:
  - input and output valid/ready handshakes with backpressure;
  - a last-of-frame marker;
  - an explicit restart for back-to-back frames.
- Sits between a sample source and a downstream consumer in the signal-processing path.

Parameters:
- DATA_W, 8, sample and result width in bits.
- DEPTH, 128, samples captured per frame (>= 2).
- STRIDE, 8, index distance between averaged pair (1 <= STRIDE < DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  data is valid this cycle.
- data  input  DATA_W  input sample.
- in_ready  output  1  block accepts a sample this cycle; high only in CAPTURE.
- out_ready  input  1  consumer accepts out this cycle.
- valid  output  1  out holds a valid average.
- out  output  DATA_W  averaged result, registered.
- last  output  1  high with valid on the final average of the frame.
- done  output  1  high in DONE state.
- restart  input  1  single-cycle pulse; starts a new frame, honoured only in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CAPTURE; capture counter, emit index, valid, out, last, done all 0.
  - Sample memory is not cleared; every frame overwrites all DEPTH entries.
  - Reset asserted mid-frame aborts the frame immediately; no partial output follows.
- State machine: CAPTURE -> EMIT -> DONE -> CAPTURE.
- CAPTURE:
  - in_ready=1. On each edge with in_valid=1: mem[cnt] <= data, cnt <= cnt+1. Gaps (in_valid=0) hold cnt.
  - On the edge accepting sample index DEPTH-1, state <= EMIT and cnt <= 0.
- EMIT:
  - in_ready=0; input is ignored.
  - Output register loads when (valid==0 || out_ready==1) and j < DEPTH-STRIDE:
    - sum = mem[j] + mem[j+STRIDE], computed at DATA_W+1 bits.
    - out <= (sum + 1) >> 1 (round half up; never overflows DATA_W).
    - valid <= 1; last <= (j == DEPTH-STRIDE-1); j <= j+1.
  - First valid is asserted on the edge after entering EMIT, i.e. 1 cycle after the final sample is accepted.
  - Backpressure: while valid=1 and out_ready=0, out, valid and last hold stable and j does not advance.
  - Full throughput: with out_ready held at 1, one result per cycle.
  - When the output with last=1 is consumed (valid && out_ready && last):
    - valid <= 0, last <= 0, state <= DONE.
    - j resets to 0 on the same edge.
- DONE:
  - done=1, in_ready=0, valid=0.
  - restart=1 -> state <= CAPTURE, cnt <= 0.
  - restart is ignored in CAPTURE and EMIT.
- Outputs per frame: exactly DEPTH-STRIDE.
- Counters are sized to $clog2(DEPTH+1) bits.

Optional Feature:
- Macro: PAIR_AVG_TRUNC_EN.
- Defined: out = sum >> 1 (truncating average).
- Undefined (default): out = (sum + 1) >> 1 (round half up).
- No other behaviour changes.

Test Plan:
1. Defaults; feed data=i for i=0..127 continuously, out_ready=1 -> 120 outputs:
   - out = i+4 on consecutive cycles starting 1 cycle after the 128th accept;
   - last only on out=123; then done=1.
2. mem[0]=3, mem[8]=4, rest 0:
   - first out=4 (default) and 3 with PAIR_AVG_TRUNC_EN;
   - all-255 frame -> every out=255, no overflow.
3. Toggle out_ready 1,0,0,1 during EMIT:
   - out/valid/last hold while out_ready=0;
   - sequence of values unchanged; still exactly 120 outputs.
4. in_valid gaps (every other cycle) during CAPTURE:
   - EMIT entered only after 128 accepted samples; outputs identical to scenario 1.
5. Pulse restart in EMIT (ignored) and in DONE (accepted):
   - second frame data=255-i -> out = 251-i, correct last and done.
6. Assert reset=0 asynchronously mid-EMIT:
   - valid/last/done/out drop to 0 immediately (before next clock edge);
   - after release, in_ready=1 and a fresh frame captures correctly.
